product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
//
// PURPOSE
//   Downstream stage of the 16x16 unsigned array multiplier. Accepts a stream of 32-bit
//   products over a valid/ready handshake and sums each burst (terminated by in_last) into
//   a wide accumulator. Presents the burst sum, element count and overflow flag in a
//   single-entry registered output with its own valid/ready handshake (dot-product / MAC tail).
//
// PARAMETERS
//   PROD_W  32  width of incoming unsigned product (multiplier output width)
//   ACC_W   40  accumulator/result width; must be >= PROD_W
//   CNT_W    8  burst element counter width
//
// PORTS
//   clk        in   1        single clock, all state updates on rising edge
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        in_prod/in_last valid this cycle
//   in_ready   out  1        block can accept a product this cycle
//   in_prod    in   PROD_W   unsigned product, zero-extended to ACC_W before adding
//   in_last    in   1        marks final product of the current burst
//   out_valid  out  1        out_acc/out_count/out_ovf hold a completed burst result
//   out_ready  in   1        consumer takes the result this cycle
//   out_acc    out  ACC_W    burst sum
//   out_count  out  CNT_W    number of products in the burst (saturating)
//   out_ovf    out  1        burst sum exceeded 2^ACC_W-1
//
// BEHAVIOUR
//   - Reset (async assert): state=ACCUM; internal acc/cnt/ovf=0; out_valid=0, out_acc=0,
//     out_count=0, out_ovf=0. A partial burst in progress is discarded.
//   - Accept on in_valid && in_ready. Output transfer on out_valid && out_ready.
//   - States: ACCUM (no result pending), DONE (result held in output register).
//   - in_ready = (state==ACCUM) || out_ready   (combinational from out_ready only).
//   - On accept, not last: acc <= acc + zext(in_prod); cnt <= cnt+1 (holds at 2^CNT_W-1);
//     ovf <= ovf | carry-out. State unchanged.
//   - On accept with in_last: out_acc/out_count/out_ovf <= next-sum/next-count/next-ovf;
//     out_valid <= 1; internal acc/cnt/ovf cleared to 0; state -> DONE.
//     Latency: result visible the cycle after the last product is accepted.
//   - DONE, out_ready=0: in_ready=0; out_* held stable; internal state frozen.
//   - DONE, out_ready=1, no accept: out_valid <= 0, state -> ACCUM.
//   - DONE, out_ready=1 and accept (simultaneous): result leaves; new product starts a fresh
//     burst from zero that cycle. If that product also has in_last, the new result is loaded,
//     out_valid stays 1, state stays DONE (one-product burst every cycle sustained).
//   - Sum wraps modulo 2^ACC_W by default; out_ovf set if any add in the burst carried out.
//   - out_acc/out_count/out_ovf only change on load; cleared only by reset.
//   - in_prod ignored when not accepted; no X-propagation into acc from an idle bus.
//
// CONFIGURATION
//   SAT_EN  defined: on carry-out the accumulator clamps to 2^ACC_W-1 and stays there for
//           the rest of the burst; out_ovf still set. Not defined: modulo-2^ACC_W wrap,
//           out_ovf set (default build).
//
// TESTING
//   1. Products 0xFFFE0001, 0x2, 0x3 (last on 3rd), out_ready=1 -> next cycle
//      out_valid=1, out_acc=0xFFFE0006, out_count=3, out_ovf=0; out_valid=0 after.
//   2. Single product 0x1234 with in_last -> out_acc=0x1234, out_count=1, one cycle later.
//   3. Result pending, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* stable;
//      raise out_ready with in_prod=0x5,in_last=1 -> old result transfers, new out_acc=0x5.
//   4. ACC_W=33: 3x 0xFFFFFFFF, last on 3rd -> out_acc=0x0FFFFFFFD, out_ovf=1;
//      with SAT_EN -> out_acc=0x1FFFFFFFF, out_ovf=1.
//   5. CNT_W=2: five products of 0x1, last on 5th -> out_acc=5, out_count=3.
//   6. Assert rst mid-burst after 2 products -> out_valid=0 immediately; next burst 0x7
//      (last) -> out_acc=0x7, out_count=1, out_ovf=0.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake bundle for the product accumulator.
// Macro: none (widths follow the parameters below).
// Signals:
//   in_valid/in_ready/in_prod/in_last       product stream into the accumulator
//   out_valid/out_ready/out_acc/out_count/out_ovf  burst result out of the accumulator
// Modports:
//   slave  - the accumulator (consumes products, produces results)
//   master - the environment (produces products, consumes results)
interface product_accumulator_if #(
    parameter int unsigned PROD_W = 32,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport slave (
        input  in_valid,
        input  in_prod,
        input  in_last,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_acc,
        output out_count,
        output out_ovf
    );

    modport master (
        output in_valid,
        output in_prod,
        output in_last,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_acc,
        input  out_count,
        input  out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Burst accumulator behind the 16x16 unsigned array multiplier.
// Sums each burst of unsigned products (terminated by in_last) into an ACC_W-bit
// accumulator and presents sum, element count and overflow flag in a single-entry
// registered result slot with its own valid/ready handshake.
// Optional feature: define SAT_EN to clamp the sum at 2^ACC_W-1 on carry-out instead
// of wrapping modulo 2^ACC_W (default build wraps).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - product_accumulator_if.slave (product stream in, result stream out)
module product_accumulator #(
    parameter int unsigned PROD_W = 32,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    product_accumulator_if.slave   bus
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned PAD_W = ACC_W - PROD_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               in_ready_c;
    logic               accept_c;
    logic [SUM_W-1:0]   sum_c;
    logic               carry_c;
    logic [ACC_W-1:0]   acc_nxt_c;
    logic [CNT_W-1:0]   cnt_nxt_c;
    logic               ovf_nxt_c;

    // Ready when nothing is pending, or when the pending result leaves this cycle.
    assign in_ready_c = (state_q == ST_ACCUM) || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;

    // Running-sum candidate; only committed on accept, so an idle bus never reaches acc.
    always_comb begin : p_datapath
        sum_c     = {1'b0, acc_q} + {{PAD_W{1'b0}}, bus.in_prod};
        carry_c   = sum_c[ACC_W];
        ovf_nxt_c = ovf_q | carry_c;
`ifdef SAT_EN
        // Once saturated, the sum stays pinned at full scale until the burst ends.
        acc_nxt_c = (ovf_q || carry_c) ? ACC_MAX : sum_c[ACC_W-1:0];
`else
        acc_nxt_c = sum_c[ACC_W-1:0];
`endif
        cnt_nxt_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state and result-slot control.
    always_comb begin : p_fsm_comb
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        unique case (state_q)
            ST_ACCUM: begin
                state_d = ST_ACCUM;
            end
            ST_DONE: begin
                // Consumer takes the result; a same-cycle last product reloads below.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        // Internal acc/cnt/ovf are already zero in DONE, so a product accepted there
        // starts a fresh burst naturally.
        if (accept_c) begin
            if (bus.in_last) begin
                out_acc_d   = acc_nxt_c;
                out_count_d = cnt_nxt_c;
                out_ovf_d   = ovf_nxt_c;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                state_d     = ST_DONE;
            end else begin
                acc_d = acc_nxt_c;
                cnt_d = cnt_nxt_c;
                ovf_d = ovf_nxt_c;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator.
// Three instances: default widths, ACC_W=33 (wrap/saturate), CNT_W=2 (count saturation).
module tb_product_accumulator;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    product_accumulator_if #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) bus_m ();
    product_accumulator_if #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) bus_w ();
    product_accumulator_if #(.PROD_W(32), .ACC_W(40), .CNT_W(2)) bus_c ();

    product_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) u_main (
        .clk (clk), .rst (rst), .bus (bus_m.slave)
    );
    product_accumulator #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) u_w33 (
        .clk (clk), .rst (rst), .bus (bus_w.slave)
    );
    product_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(2)) u_c2 (
        .clk (clk), .rst (rst), .bus (bus_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus_m.out_valid !== 1'b0 || bus_m.out_acc !== 40'h0 || bus_m.out_count !== 8'h0 || bus_m.out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b acc=%h cnt=%h ovf=%b, expected all zero", bus_m.out_valid, bus_m.out_acc, bus_m.out_count, bus_m.out_ovf);
        end
        tests_run++;
        if (bus_m.in_ready !== 1'b1 || bus_w.in_ready !== 1'b1 || bus_c.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b%b%b expected 111", bus_m.in_ready, bus_w.in_ready, bus_c.in_ready);
        end
    endtask

    task automatic test_basic_burst();
        logic [31:0] prods [3];
        prods[0] = 32'hFFFE0001;
        prods[1] = 32'h00000002;
        prods[2] = 32'h00000003;
        bus_m.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_m.in_valid = 1'b1;
            bus_m.in_prod  = prods[i];
            bus_m.in_last  = (i == 2);
            step();
            if (i < 2) begin
                tests_run++;
                if (bus_m.out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL burst_early_valid: got %b expected 0 after product %0d", bus_m.out_valid, i);
                end
            end
        end
        bus_m.in_valid = 1'b0;
        bus_m.in_last  = 1'b0;
        tests_run++;
        if (bus_m.out_valid !== 1'b1 || bus_m.out_acc !== 40'h00FFFE0006 || bus_m.out_count !== 8'd3 || bus_m.out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_result: got v=%b acc=%h cnt=%0d ovf=%b expected v=1 acc=00fffe0006 cnt=3 ovf=0", bus_m.out_valid, bus_m.out_acc, bus_m.out_count, bus_m.out_ovf);
        end
        step();
        tests_run++;
        if (bus_m.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_drain: out_valid got %b expected 0", bus_m.out_valid);
        end
    endtask

    task automatic test_single();
        bus_m.out_ready = 1'b1;
        bus_m.in_valid  = 1'b1;
        bus_m.in_prod   = 32'h1234;
        bus_m.in_last   = 1'b1;
        step();
        bus_m.in_valid = 1'b0;
        bus_m.in_last  = 1'b0;
        bus_m.in_prod  = 32'hDEADBEEF;
        tests_run++;
        if (bus_m.out_valid !== 1'b1 || bus_m.out_acc !== 40'h1234 || bus_m.out_count !== 8'd1 || bus_m.out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_result: got v=%b acc=%h cnt=%0d ovf=%b expected v=1 acc=1234 cnt=1 ovf=0", bus_m.out_valid, bus_m.out_acc, bus_m.out_count, bus_m.out_ovf);
        end
        step();
    endtask

    task automatic test_backpressure();
        bus_m.out_ready = 1'b0;
        bus_m.in_valid  = 1'b1;
        bus_m.in_prod   = 32'h10;
        bus_m.in_last   = 1'b1;
        step();
        bus_m.in_prod = 32'h99;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (bus_m.in_ready !== 1'b0 || bus_m.out_valid !== 1'b1 || bus_m.out_acc !== 40'h10 || bus_m.out_count !== 8'd1) begin
                tests_failed++;
                $display("FAIL stall_%0d: got rdy=%b v=%b acc=%h cnt=%0d expected rdy=0 v=1 acc=10 cnt=1", i, bus_m.in_ready, bus_m.out_valid, bus_m.out_acc, bus_m.out_count);
            end
            step();
        end
        bus_m.out_ready = 1'b1;
        bus_m.in_prod   = 32'h5;
        #1;
        tests_run++;
        if (bus_m.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release_ready: got %b expected 1", bus_m.in_ready);
        end
        step();
        bus_m.in_valid = 1'b0;
        bus_m.in_last  = 1'b0;
        tests_run++;
        if (bus_m.out_valid !== 1'b1 || bus_m.out_acc !== 40'h5 || bus_m.out_count !== 8'd1 || bus_m.out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_reload: got v=%b acc=%h cnt=%0d ovf=%b expected v=1 acc=5 cnt=1 ovf=0", bus_m.out_valid, bus_m.out_acc, bus_m.out_count, bus_m.out_ovf);
        end
        step();
        tests_run++;
        if (bus_m.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_drain: out_valid got %b expected 0", bus_m.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] exp_acc [4];
        exp_acc[0] = 40'h1;
        exp_acc[1] = 40'h22;
        exp_acc[2] = 40'h333;
        exp_acc[3] = 40'h4444;
        bus_m.out_ready = 1'b1;
        bus_m.in_valid  = 1'b1;
        bus_m.in_last   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_m.in_prod = exp_acc[i][31:0];
            step();
            tests_run++;
            if (bus_m.out_valid !== 1'b1 || bus_m.out_acc !== exp_acc[i] || bus_m.out_count !== 8'd1) begin
                tests_failed++;
                $display("FAIL b2b_%0d: got v=%b acc=%h cnt=%0d expected v=1 acc=%h cnt=1", i, bus_m.out_valid, bus_m.out_acc, bus_m.out_count, exp_acc[i]);
            end
        end
        bus_m.in_valid = 1'b0;
        bus_m.in_last  = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        logic [32:0] exp_acc;
`ifdef SAT_EN
        exp_acc = 33'h1FFFFFFFF;
`else
        exp_acc = 33'h0FFFFFFFD;
`endif
        bus_w.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_w.in_valid = 1'b1;
            bus_w.in_prod  = 32'hFFFFFFFF;
            bus_w.in_last  = (i == 2);
            step();
        end
        bus_w.in_valid = 1'b0;
        bus_w.in_last  = 1'b0;
        tests_run++;
        if (bus_w.out_valid !== 1'b1 || bus_w.out_acc !== exp_acc || bus_w.out_count !== 8'd3 || bus_w.out_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_result: got v=%b acc=%h cnt=%0d ovf=%b expected v=1 acc=%h cnt=3 ovf=1", bus_w.out_valid, bus_w.out_acc, bus_w.out_count, bus_w.out_ovf, exp_acc);
        end
        step();
        // Overflow must not leak into the next burst.
        bus_w.in_valid = 1'b1;
        bus_w.in_prod  = 32'h9;
        bus_w.in_last  = 1'b1;
        step();
        bus_w.in_valid = 1'b0;
        bus_w.in_last  = 1'b0;
        tests_run++;
        if (bus_w.out_acc !== 33'h9 || bus_w.out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_cleared: got acc=%h ovf=%b expected acc=9 ovf=0", bus_w.out_acc, bus_w.out_ovf);
        end
        step();
    endtask

    task automatic test_count_sat();
        bus_c.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_c.in_valid = 1'b1;
            bus_c.in_prod  = 32'h1;
            bus_c.in_last  = (i == 4);
            step();
        end
        bus_c.in_valid = 1'b0;
        bus_c.in_last  = 1'b0;
        tests_run++;
        if (bus_c.out_valid !== 1'b1 || bus_c.out_acc !== 40'h5 || bus_c.out_count !== 2'd3 || bus_c.out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL cnt_sat: got v=%b acc=%h cnt=%0d ovf=%b expected v=1 acc=5 cnt=3 ovf=0", bus_c.out_valid, bus_c.out_acc, bus_c.out_count, bus_c.out_ovf);
        end
        step();
    endtask

    task automatic test_reset_mid_burst();
        bus_m.out_ready = 1'b1;
        bus_m.in_valid  = 1'b1;
        bus_m.in_last   = 1'b0;
        bus_m.in_prod   = 32'h100;
        step();
        bus_m.in_prod = 32'h200;
        step();
        bus_m.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus_m.out_valid !== 1'b0 || bus_m.out_acc !== 40'h0 || bus_m.out_count !== 8'h0) begin
            tests_failed++;
            $display("FAIL rst_async: got v=%b acc=%h cnt=%0d expected v=0 acc=0 cnt=0", bus_m.out_valid, bus_m.out_acc, bus_m.out_count);
        end
        step();
        rst = 1'b0;
        step();
        bus_m.in_valid = 1'b1;
        bus_m.in_prod  = 32'h7;
        bus_m.in_last  = 1'b1;
        step();
        bus_m.in_valid = 1'b0;
        bus_m.in_last  = 1'b0;
        tests_run++;
        if (bus_m.out_valid !== 1'b1 || bus_m.out_acc !== 40'h7 || bus_m.out_count !== 8'd1 || bus_m.out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_fresh_burst: got v=%b acc=%h cnt=%0d ovf=%b expected v=1 acc=7 cnt=1 ovf=0", bus_m.out_valid, bus_m.out_acc, bus_m.out_count, bus_m.out_ovf);
        end
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus_m.in_valid = 1'b0; bus_m.in_prod = '0; bus_m.in_last = 1'b0; bus_m.out_ready = 1'b0;
        bus_w.in_valid = 1'b0; bus_w.in_prod = '0; bus_w.in_last = 1'b0; bus_w.out_ready = 1'b0;
        bus_c.in_valid = 1'b0; bus_c.in_prod = '0; bus_c.in_last = 1'b0; bus_c.out_ready = 1'b0;

        test_reset();
        test_basic_burst();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_count_sat();
        test_reset_mid_burst();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
